bus_rx: RTL and testbench

Target-mode I3C bus receiver: samples SDA on the bus, one bit or one MSB-first byte per request, using the same SCL edge/level events that the transmitter consumes. It sits beside the transmit driver under the target controller FSM, which issues receive requests and consumes the received data, done and error pulses. SDA sampling is delayed by a programmable number of clock cycles after each SCL rising edge. Any SDA change while SCL is high after sampling is reported as a framing error, because it is a START or STOP.

---
 rtl/bus_rx_pkg.sv | 17 +
 rtl/bus_timer.sv | 26 ++
 rtl/bus_rx.sv | 140 ++++++++++++++
 tb/tb_bus_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bus_rx_pkg.sv
// Shared target-controller definitions: bus timing width and receive mode.
package bus_rx_pkg;

  localparam int unsigned TimingW = 20;
  localparam int unsigned RxCntW  = 4;

  typedef enum logic {
    RxBit  = 1'b0,
    RxByte = 1'b1
  } rx_mode_e;

  // Number of bits a request of the given mode transfers.
  function automatic logic [RxCntW-1:0] rx_bit_count(rx_mode_e mode);
    return (mode == RxByte) ? RxCntW'(8) : RxCntW'(1);
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Loadable 20-bit down-counter that saturates at zero; shared bus timing helper.
module bus_timer
  import bus_rx_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [TimingW-1:0] load_val_i,
  output logic [TimingW-1:0] count_o
);

  logic [TimingW-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - TimingW'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bus_rx.sv
// Target-mode I3C receiver: samples SDA a programmable delay after each SCL
// rising edge and flags any SDA change while SCL stays high (START/STOP).
module bus_rx
  import bus_rx_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [TimingW-1:0] t_sample_i,
  input  logic               rx_req_bit_i,
  input  logic               rx_req_byte_i,
  input  logic               sda_i,
  input  logic               scl_posedge_i,
  input  logic               scl_negedge_i,
  output logic               rx_idle_o,
  output logic               rx_done_o,
  output logic               rx_error_o,
  output logic [7:0]         rx_data_o
);

  typedef enum logic [1:0] {
    Idle         = 2'd0,
    AwaitPosedge = 2'd1,
    SampleDelay  = 2'd2,
    AwaitNegedge = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          data_q, data_d;
  logic [RxCntW-1:0]   cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                idle_q;
  logic                timer_load;
  logic [TimingW-1:0]  timer;
  rx_mode_e            mode;

  bus_timer u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (timer_load),
    .load_val_i (t_sample_i),
    .count_o    (timer)
  );

  // Next-state, shift register, bit counter and pulse generation.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    timer_load = 1'b0;
    mode       = rx_req_byte_i ? RxByte : RxBit;

    unique case (state_q)
      Idle: begin
        if (rx_req_byte_i || rx_req_bit_i) begin
          data_d = '0;
          cnt_d  = rx_bit_count(mode);
          if (scl_posedge_i) begin
            // The accepting cycle doubles as this bit's SCL posedge.
            timer_load = 1'b1;
            if (t_sample_i == '0) begin
              data_d  = {data_d[6:0], sda_i};
              state_d = AwaitNegedge;
            end else begin
              state_d = SampleDelay;
            end
          end else begin
            state_d = AwaitPosedge;
          end
        end
      end

      AwaitPosedge: begin
        if (scl_posedge_i) begin
          timer_load = 1'b1;
          if (t_sample_i == '0) begin
            data_d  = {data_q[6:0], sda_i};
            state_d = AwaitNegedge;
          end else begin
            state_d = SampleDelay;
          end
        end
      end

      SampleDelay: begin
        // SCL falling before the sample point leaves no valid bit.
        if (scl_negedge_i) begin
          err_d   = 1'b1;
          state_d = Idle;
        end else if (timer == TimingW'(1)) begin
          data_d  = {data_q[6:0], sda_i};
          state_d = AwaitNegedge;
        end
      end

      AwaitNegedge: begin
        if (scl_negedge_i) begin
          cnt_d = cnt_q - RxCntW'(1);
          if (cnt_q == RxCntW'(1)) begin
            done_d  = 1'b1;
            state_d = Idle;
          end else begin
            state_d = AwaitPosedge;
          end
        end else if (sda_i != data_q[0]) begin
          err_d   = 1'b1;
          state_d = Idle;
        end
      end

      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      idle_q  <= (state_d == Idle);
    end
  end

  assign rx_idle_o  = idle_q;
  assign rx_done_o  = done_q;
  assign rx_error_o = err_q;
  assign rx_data_o  = data_q;

endmodule

// File: tb/tb_bus_rx.sv
// Self-checking bench for bus_rx: drives SCL/SDA bit frames and checks
// results against transaction-level expectations.
module tb_bus_rx;
  import bus_rx_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [TimingW-1:0] t_sample;
  logic               req_bit, req_byte, sda, pos, neg;
  logic               idle, done, err;
  logic [7:0]         data;

  int vectors = 0;
  int miscompares = 0;
  int n_done, n_err;

  always #5 clk = ~clk;

  bus_rx dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .t_sample_i    (t_sample),
    .rx_req_bit_i  (req_bit),
    .rx_req_byte_i (req_byte),
    .sda_i         (sda),
    .scl_posedge_i (pos),
    .scl_negedge_i (neg),
    .rx_idle_o     (idle),
    .rx_done_o     (done),
    .rx_error_o    (err),
    .rx_data_o     (data)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (done === 1'b1) n_done++;
    if (err === 1'b1) n_err++;
  endtask

  // One bus transfer: per bit, 2 low cycles, posedge, `hi` cycles high, negedge.
  // Model rules: a bit is sampled only if the sample point precedes the
  // negedge; SDA moving while SCL is high after sampling aborts; result is
  // the byte (or the lone bit zero-extended); exactly one done per success.
  task automatic xfer(input logic [7:0] val, input bit byte_mode, input int t,
                      input int hi, input bit req_with_pos, input int glitch_bit,
                      input int busy_bit, input int rst_bit);
    int nbits;
    logic [7:0] expv;
    logic b;
    nbits = byte_mode ? 8 : 1;
    expv  = byte_mode ? val : {7'b0, val[0]};
    n_done = 0;
    n_err  = 0;
    t_sample = TimingW'(t);
    for (int i = 0; i < nbits; i++) begin
      b   = val[nbits-1-i];
      sda = b;
      if (i == 0 && !req_with_pos) begin
        if (byte_mode) req_byte = 1'b1; else req_bit = 1'b1;
      end
      if (i == busy_bit) req_byte = 1'b1;
      if (i == rst_bit) begin
        #2 rst_n = 1'b0;
        #1;
        chk1("rst_idle", idle, 1'b1);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk8("rst_data", data, 8'h00);
        step();
        rst_n = 1'b1;
        req_byte = 1'b0;
        req_bit  = 1'b0;
        chk1("rst_no_pulse", (n_done == 0) && (n_err == 0), 1'b1);
        return;
      end
      step();
      req_bit  = 1'b0;
      req_byte = 1'b0;
      step();
      pos = 1'b1;
      if (i == 0 && req_with_pos) begin
        if (byte_mode) req_byte = 1'b1; else req_bit = 1'b1;
      end
      step();
      pos = 1'b0;
      req_bit  = 1'b0;
      req_byte = 1'b0;
      for (int j = 1; j < hi; j++) begin
        if (i == glitch_bit && j == t + 1) sda = ~b;
        step();
        if (i == glitch_bit && j == t + 1) begin
          chk1("glitch_err", err, 1'b1);
          chk1("glitch_idle", idle, 1'b1);
          chk1("glitch_no_done", n_done == 0, 1'b1);
          step();
          chk1("glitch_err_single", err, 1'b0);
          return;
        end
      end
      neg = 1'b1;
      step();
      neg = 1'b0;
      if (t >= hi) begin
        chk1("early_neg_err", err, 1'b1);
        chk1("early_neg_idle", idle, 1'b1);
        chk1("early_neg_no_done", n_done == 0, 1'b1);
        step();
        chk1("early_neg_err_single", err, 1'b0);
        return;
      end
    end
    chk1("done_pulse", done, 1'b1);
    chk8("rx_data", data, expv);
    chk1("idle_after_done", idle, 1'b1);
    chk1("no_error", n_err == 0, 1'b1);
    step();
    chk1("done_single", done, 1'b0);
    chk1("done_count", n_done == 1, 1'b1);
    chk8("data_held", data, expv);
  endtask

  initial begin
    int hi, t;
    logic [7:0] v;
    bit bm, rp;

    rst_n = 1'b0;
    t_sample = '0;
    req_bit = 1'b0;
    req_byte = 1'b0;
    sda = 1'b1;
    pos = 1'b0;
    neg = 1'b0;
    n_done = 0;
    n_err = 0;
    step();
    step();
    chk1("reset_idle", idle, 1'b1);
    chk1("reset_done", done, 1'b0);
    chk1("reset_err", err, 1'b0);
    chk8("reset_data", data, 8'h00);
    rst_n = 1'b1;
    step();

    xfer(8'hA5, 1'b1, 3, 10, 1'b0, -1, -1, -1);
    xfer(8'h01, 1'b0, 0, 4, 1'b1, -1, -1, -1);
    xfer(8'h6B, 1'b1, 5, 3, 1'b0, -1, -1, -1);
    xfer(8'hB2, 1'b1, 2, 8, 1'b0, 2, -1, -1);
    xfer(8'h3C, 1'b1, 2, 6, 1'b0, -1, 4, -1);
    xfer(8'hF0, 1'b1, 1, 5, 1'b0, -1, -1, 4);
    xfer(8'hFF, 1'b1, 1, 5, 1'b0, -1, -1, -1);

    for (int k = 0; k < 12; k++) begin
      v  = 8'($urandom);
      bm = 1'($urandom_range(0, 1));
      rp = 1'($urandom_range(0, 1));
      hi = int'($urandom_range(2, 12));
      t  = int'($urandom_range(0, 32'(hi - 1)));
      xfer(v, bm, t, hi, rp, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
